// File: rtl/fpu_issue_sequencer_if.sv
// Bundle of the core request/response signals and the seven FPU AXI-Stream
// channels. The sequencer uses the master view; its environment uses the slave view.
interface fpu_issue_sequencer_if;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [31:0]  req_a;
  logic [31:0]  req_b;
  logic         abort;
  logic         busy;
  logic         done;
  logic [31:0]  result;
  logic [1:0]   err;
  logic [31:0]  a_tdata;
  logic [31:0]  b_tdata;
  logic [7:0]   op_tdata;
  logic [6:0]   in_tvalid;
  logic [6:0]   in_tready;
  logic [223:0] r_tdata;
  logic [6:0]   r_tvalid;
  logic [6:0]   r_tready;

  modport master (
    input  req_valid, req_op, req_a, req_b, abort, in_tready, r_tdata, r_tvalid,
    output req_ready, busy, done, result, err, a_tdata, b_tdata, op_tdata,
           in_tvalid, r_tready
  );

  modport slave (
    output req_valid, req_op, req_a, req_b, abort, in_tready, r_tdata, r_tvalid,
    input  req_ready, busy, done, result, err, a_tdata, b_tdata, op_tdata,
           in_tvalid, r_tready
  );
endinterface

// File: rtl/fpu_issue_sequencer.sv
// Single-issue sequencer: steers one FPU op to its AXI-Stream unit, collects
// and normalises the result, with abort draining and a hang timeout.
module fpu_issue_sequencer #(
  parameter int TIMEOUT = 1023
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  fpu_issue_sequencer_if.master  tif
);

  localparam int DATA_W    = 32;
  localparam int NUM_UNITS = 7;
  localparam int CNT_W     = $clog2(TIMEOUT + 1);

  localparam logic [2:0] U_ADDSUB = 3'd0;
  localparam logic [2:0] U_MUL    = 3'd1;
  localparam logic [2:0] U_DIV    = 3'd2;
  localparam logic [2:0] U_COMP   = 3'd3;
  localparam logic [2:0] U_FCVTSW = 3'd4;
  localparam logic [2:0] U_FCVTWS = 3'd5;
  localparam logic [2:0] U_FSQRTS = 3'd6;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_DONE} state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return (op <= 4'd9);
  endfunction

  function automatic logic [2:0] unit_of(input logic [3:0] op);
    logic [2:0] u;
    case (op)
      4'd0, 4'd1:       u = U_ADDSUB;
      4'd2:             u = U_MUL;
      4'd3:             u = U_DIV;
      4'd4, 4'd5, 4'd6: u = U_COMP;
      4'd7:             u = U_FCVTSW;
      4'd8:             u = U_FCVTWS;
      4'd9:             u = U_FSQRTS;
      default:          u = U_ADDSUB;
    endcase
    return u;
  endfunction

  // Sub-op code understood by the addsub and comp units.
  function automatic logic [7:0] op_code_of(input logic [3:0] op);
    logic [7:0] c;
    case (op)
      4'd1:    c = 8'h01;
      4'd4:    c = 8'h14;
      4'd5:    c = 8'h0C;
      4'd6:    c = 8'h1C;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [NUM_UNITS-1:0] onehot(input logic [2:0] u);
    return NUM_UNITS'(1) << u;
  endfunction

  // Comparator results carry a single meaningful bit in position 0.
  function automatic logic [DATA_W-1:0] normalise(input logic [2:0] u,
                                                  input logic [NUM_UNITS*DATA_W-1:0] data);
    logic [DATA_W-1:0] raw;
    raw = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (u == 3'(i)) raw = data[i*DATA_W +: DATA_W];
    end
    return (u == U_COMP) ? {{(DATA_W-1){1'b0}}, raw[0]} : raw;
  endfunction

  state_t                state_q, state_d;
  logic [2:0]            unit_q, unit_d;
  logic                  abort_q, abort_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  done_q, done_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic [1:0]            err_q, err_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [7:0]            opc_q, opc_d;
  logic [NUM_UNITS-1:0]  in_tvalid_q, in_tvalid_d;
  logic [NUM_UNITS-1:0]  r_tready_q, r_tready_d;

  logic aborted;
  logic in_hs;
  logic r_hs;
  logic expired;

  assign aborted = abort_q | tif.abort;
  assign in_hs   = |(in_tvalid_q & tif.in_tready);
  assign r_hs    = |(r_tready_q & tif.r_tvalid);
  assign expired = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    unit_d      = unit_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    result_d    = result_q;
    err_d       = err_q;
    a_d         = a_q;
    b_d         = b_q;
    opc_d       = opc_q;
    in_tvalid_d = in_tvalid_q;
    r_tready_d  = r_tready_q;

    case (state_q)
      ST_IDLE: begin
        if (tif.req_valid) begin
          unit_d  = unit_of(tif.req_op);
          a_d     = tif.req_a;
          b_d     = tif.req_b;
          opc_d   = op_code_of(tif.req_op);
          abort_d = 1'b0;
          cnt_d   = '0;
          if (is_legal(tif.req_op)) begin
            in_tvalid_d = onehot(unit_of(tif.req_op));
            state_d     = ST_ISSUE;
          end else begin
            done_d   = 1'b1;
            err_d    = ERR_ILLEGAL;
            result_d = '0;
            state_d  = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        abort_d = aborted;
        if (in_hs) begin
          in_tvalid_d = '0;
          r_tready_d  = onehot(unit_q);
          state_d     = ST_WAIT;
        end else if (expired) begin
          // Fault recovery: the only path that withdraws tvalid unacknowledged.
          in_tvalid_d = '0;
          if (aborted) begin
            state_d = ST_IDLE;
          end else begin
            done_d   = 1'b1;
            err_d    = ERR_TIMEOUT;
            result_d = '0;
            state_d  = ST_DONE;
          end
        end
      end

      ST_WAIT: begin
        cnt_d   = cnt_q + CNT_W'(1);
        abort_d = aborted;
        if (r_hs) begin
          r_tready_d = '0;
          if (aborted) begin
            state_d = ST_IDLE;
          end else begin
            done_d   = 1'b1;
            err_d    = ERR_OK;
            result_d = normalise(unit_q, tif.r_tdata);
            state_d  = ST_DONE;
          end
        end else if (expired) begin
          r_tready_d = '0;
          if (aborted) begin
            state_d = ST_IDLE;
          end else begin
            done_d   = 1'b1;
            err_d    = ERR_TIMEOUT;
            result_d = '0;
            state_d  = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      unit_q      <= '0;
      abort_q     <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      err_q       <= ERR_OK;
      a_q         <= '0;
      b_q         <= '0;
      opc_q       <= '0;
      in_tvalid_q <= '0;
      r_tready_q  <= '0;
    end else begin
      state_q     <= state_d;
      unit_q      <= unit_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      result_q    <= result_d;
      err_q       <= err_d;
      a_q         <= a_d;
      b_q         <= b_d;
      opc_q       <= opc_d;
      in_tvalid_q <= in_tvalid_d;
      r_tready_q  <= r_tready_d;
    end
  end

  assign tif.req_ready = (state_q == ST_IDLE);
  assign tif.busy      = (state_q != ST_IDLE);
  assign tif.done      = done_q;
  assign tif.result    = result_q;
  assign tif.err       = err_q;
  assign tif.a_tdata   = a_q;
  assign tif.b_tdata   = b_q;
  assign tif.op_tdata  = opc_q;
  assign tif.in_tvalid = in_tvalid_q;
  assign tif.r_tready  = r_tready_q;

endmodule

// File: doc/fpu_issue_sequencer.md
# fpu_issue_sequencer

Single-issue sequencer between the core execute stage and the seven AXI-Stream floating-point units (addsub, mul, div, comp, fcvtsw, fcvtws, fsqrts). It accepts one FPU operation at a time and steers operands to the selected unit with a legal AXI-Stream handshake. It collects that unit's result, normalises it, and returns it with a one-cycle done pulse. It also provides a stall signal, an abort path and a hang timeout.

## Interface
- TIMEOUT, 1023: max cycles spent in ISSUE+WAIT before the op is abandoned (≥2)
- CLK  in  1  clock
- RST_N  in  1  reset; one clock, reset is asynchronous and active-low
- req_valid  in  1  op request from core
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_op  in  4  0 fadds, 1 fsubs, 2 fmuls, 3 fdivs, 4 feqs, 5 flts, 6 fles, 7 fcvtsw, 8 fcvtws, 9 fsqrts; 10–15 illegal
- req_a  in  32  operand A (frs1, or rs1 for fcvtsw)
- req_b  in  32  operand B (frs2)
- abort  in  1  core flush; discard the in-flight op
- busy  out  1  stall to core; high in every state except IDLE
- done  out  1  one-cycle completion pulse
- result  out  32  result, valid when done
- err  out  2  with done: 00 ok, 01 timeout, 10 illegal opcode
- a_tdata, b_tdata  out  32 each  operands broadcast to all units
- op_tdata  out  8  operation code broadcast (addsub, comp)
- in_tvalid  out  7  one-hot operand valid; bit order addsub, mul, div, comp, fcvtsw, fcvtws, fsqrts
- in_tready  in  7  per-unit operand ready (AND of that unit's channel treadys, formed at top level)
- r_tdata  in  224  per-unit results; unit i at [32i+31:32i]
- r_tvalid  in  7  per-unit result valid
- r_tready  out  7  one-hot result ready

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**
  - On req_valid&&req_ready, register op, unit index, a_tdata, b_tdata and op_tdata.
  - Legal op → ISSUE.
  - Illegal op → DONE with err=10, result=0; no unit is touched.
- **op_tdata encoding:** fsubs 0x01; other addsub 0x00; feqs 0x14; flts 0x0C; fles 0x1C; all others 0x00.
- **ISSUE**
  - in_tvalid[unit]=1; operand buses stay stable until in_tvalid&in_tready.
  - On handshake → WAIT.
- **WAIT**
  - r_tready[unit]=1.
  - On r_tvalid[unit]&r_tready[unit], capture the result → DONE.
  - Comp unit results are zero-extended from bit 0; all other units pass 32 bits through.
- **DONE**
  - done=1 for exactly one cycle with result/err → IDLE.
- **Unselected units:** r_tvalid on any unselected unit is ignored; its r_tready stays 0.
- **Abort**
  - In IDLE or DONE: no effect.
  - In ISSUE: tvalid is not dropped. An abort flag is set and the handshake completes normally.
  - In WAIT, or with the abort flag set: the result is drained (r_tready held until r_tvalid), then → IDLE with no done pulse.
- **Timeout**
  - A counter of width clog2(TIMEOUT+1) clears on entry to ISSUE and increments every ISSUE/WAIT cycle.
  - When it equals TIMEOUT and no handshake occurs that cycle: drop in_tvalid/r_tready and go → DONE with err=01, result=0.
  - This is a fault-recovery path and is the only case where tvalid is withdrawn without a handshake.
  - An aborted op that times out → IDLE with no done pulse.
- **Reset** (any state, asynchronous): outputs return to reset values, state=IDLE, abort flag and counter cleared. The next op after reset deasserts must be issued normally.

## Timing
- **Reset values:** req_ready=1, busy=0, done=0, result=0, err=00, a/b/op_tdata=0, in_tvalid=0, r_tready=0.
- All outputs are registered except req_ready and busy, which are decoded from the state register.
- **Minimum latency:**
  - Accept at cycle T.
  - in_tvalid high at T+1; handshake at T+1 if tready is already high.
  - r_tready high at T+2.
  - done at T+3 if r_tvalid is high at T+2.
  - req_ready back high at T+4.
- Illegal op: accept T, done at T+1.
- Back-to-back throughput: one op per (latency+1) cycles; never more than one op in flight.
- Abort and handshake in the same cycle in ISSUE: the handshake is taken and the op is treated as aborted.
- Abort and result in the same cycle in WAIT: the result is discarded and there is no done pulse.

## Test plan
- **Basic fadds:** req_op=0, a=0x3F800000, b=0x40000000; addsub tready=1; r_tvalid 5 cycles later with 0x40400000 → done once, result=0x40400000, err=00, op_tdata=0x00, only in_tvalid[0]/r_tready[0] asserted.
- **Stable operands under backpressure:** flts with comp in_tready low for 4 cycles → in_tvalid[3] held and a/b/op_tdata (0x0C) stable for 4 cycles. Then r_tdata[127:96]=0xFFFFFFFF → result=0x00000001.
- **Stray results:** fdivs with r_tvalid[1] pulsed during WAIT → ignored, r_tready[1]=0; completes on r_tvalid[2].
- **Abort during ISSUE:** fsqrts with abort pulsed → handshake completes, result drained, done never asserts, req_ready returns high.
- **Timeout and illegal opcode:** TIMEOUT=16 and fmuls never receives r_tvalid → done with err=01, result=0, 16 cycles after issue. req_op=12 → done one cycle after accept with err=10.
- **Mid-operation reset:** RST_N dropped asynchronously in WAIT → all outputs at reset values immediately; a following fcvtsw (a=5) completes with 0x40A00000.
